dutsig_vector_seq: RTL and testbench
====================================

// Module: dutsig_vector_seq
// PURPOSE
//   Sequencer for a bank of NSIG double-buffered DUT signal registers (LOAD fills the buffer, TRANSFER drives the pin register).
//   Pulls test vectors from an upstream stream, LOADs each into the buffers, then fires TRANSFER on a programmed period.
//   Never issues LOAD and TRANSFER in the same cycle: in the DUT register, LOAD has priority and would swallow the TRANSFER.
//   Sits between the vector memory/stream and the DUT signal register bank in the ASIC tester.
// PARAMETERS
//   NSIG      8   number of DUT signals (width of VEC_DATA and D)
//   PERIOD_W  16  width of PERIOD (cycles between TRANSFERs)
//   CNT_W     16  width of NUM_VEC and the vector counters
// PORTS
//   CLK        in   1         system clock; all state updates on posedge
//   RST_N      in   1         asynchronous reset, active-low
//   START      in   1         pulse; begins a run with the current PERIOD/NUM_VEC (ignored unless IDLE)
//   ABORT      in   1         pulse; ends any run immediately
//   PERIOD     in   PERIOD_W  cycles between TRANSFERs; legal range >= 2
//   NUM_VEC    in   CNT_W     vectors in the run; legal range >= 1
//   VEC_DATA   in   NSIG      vector from upstream
//   VEC_VALID  in   1         upstream has a vector
//   VEC_READY  out  1         combinational; a vector is accepted when VEC_VALID && VEC_READY
//   LOAD       out  1         registered pulse to every DUT register's LOAD
//   TRANSFER   out  1         registered pulse to every DUT register's TRANSFER
//   D          out  NSIG      registered data for the DUT register D inputs; valid while LOAD = 1
//   BUSY       out  1         high in PRELOAD and RUN
//   DONE       out  1         one-cycle pulse, in the same cycle as the final TRANSFER
//   UNDERRUN   out  1         sticky: a TRANSFER slot found no buffered vector; cleared by START
//   CFG_ERR    out  1         one-cycle pulse: START rejected because PERIOD < 2 or NUM_VEC == 0
// BEHAVIOUR
//   Reset
//     All outputs are 0, D = 0, state = IDLE, counters = 0, buf_full = 0.
//   IDLE
//     VEC_READY = 0.
//     Legal START: latch PERIOD and NUM_VEC, clear UNDERRUN, go to PRELOAD.
//     Illegal START: CFG_ERR pulses next cycle, stay in IDLE.
//   PRELOAD
//     VEC_READY = 1.
//     Accept at cycle t: LOAD = 1 and D = data at t+1; buf_full set; loads = 1; state = RUN at t+1 with timer = 0.
//     First TRANSFER therefore occurs at t+2.
//   RUN timer
//     The timer decrements every cycle and reloads PERIOD-1 after reaching 0.
//     timer == 0 && buf_full: TRANSFER at the next cycle; buf_full cleared; xfers incremented.
//     timer == 0 && !buf_full: slot skipped, no TRANSFER, UNDERRUN set; later vectors shift to later slots.
//   RUN fetch
//     VEC_READY = !buf_full && loads < NUM_VEC && timer != 0.
//     The timer != 0 term keeps LOAD (t+1) and TRANSFER (t+2) in distinct cycles.
//     Accept: LOAD the next cycle; buf_full set; loads incremented.
//   Completion
//     The TRANSFER that makes xfers == NUM_VEC also pulses DONE; state returns to IDLE the cycle DONE is high.
//     Steady state: TRANSFERs are exactly PERIOD cycles apart.
//   ABORT
//     Takes priority over all other events; from any state, IDLE at the next edge.
//     LOAD, TRANSFER and DONE are 0 from the next cycle.
//     Buffered vector is discarded; UNDERRUN is kept.
//   START while BUSY is ignored. START and ABORT in the same cycle: ABORT wins.
//   PERIOD and NUM_VEC changes during a run have no effect (the values are latched).
//   Counters are CNT_W bits; NUM_VEC = 2^CNT_W - 1 completes without wrap.
// CONFIGURATION
//   DUTSEQ_VEC_COUNT_EN defined: adds output VEC_COUNT [CNT_W] = xfers.
//     Holds its final value after DONE or ABORT; cleared by a legal START and by reset.
//   DUTSEQ_VEC_COUNT_EN undefined: the port is absent; all other behaviour is identical.
// STRUCTURE
//   dutsig_seq_defs.vh (shared): state encodings IDLE/PRELOAD/RUN and the minimum-PERIOD constant (2).
//   Sub-module dutsig_period_timer: PERIOD_W down-counter.
//     Inputs: load, reload value, enable. Output: terminal flag (timer == 0).
//   The top level holds the FSM, buf_full, the loads/xfers counters and the output registers.
// TESTING
//   1. PERIOD=4, NUM_VEC=3, VEC_VALID held 1 with data 8'hA1, 8'hB2, 8'hC3:
//      LOAD with D=A1 at t+1 after the first accept; TRANSFERs at t+2, t+6, t+10; DONE with the last; UNDERRUN=0.
//   2. PERIOD=3, NUM_VEC=2, second vector withheld for 8 cycles: UNDERRUN=1; two slots skipped; exactly 2 TRANSFERs.
//   3. Every run: LOAD and TRANSFER never high in the same cycle.
//      Each TRANSFER is preceded by exactly one LOAD since the previous TRANSFER.
//   4. ABORT one cycle after the second LOAD: BUSY=0 next cycle; no further LOAD/TRANSFER; no DONE; a new START works.
//   5. START with PERIOD=1 or NUM_VEC=0: CFG_ERR one-cycle pulse; BUSY stays 0.
//   6. RST_N asserted mid-RUN, asynchronously: all outputs 0 immediately.
//      After release a normal run completes; with DUTSEQ_VEC_COUNT_EN, VEC_COUNT == NUM_VEC after DONE.

Source files
------------

// File: rtl/dutsig_vector_seq_pkg.sv
// Shared definitions for the DUT signal vector sequencer: FSM state encodings
// and the smallest PERIOD a run may be started with.
package dutsig_vector_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  // A period of 1 would force LOAD and TRANSFER into the same cycle.
  localparam int unsigned MIN_PERIOD = 32'd2;

endpackage

// File: rtl/dutsig_vector_seq_period_timer.sv
// Period down-counter for the vector sequencer: load presets the count to zero
// so the terminal flag fires at once, then it wraps to the reload value.
module dutsig_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] reload,
  input  logic                enable,
  output logic                terminal
);

  logic [PERIOD_W-1:0] count_r;

  // Count down while enabled, reloading after the terminal cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == '0) begin
        count_r <= reload;
      end else begin
        count_r <= count_r - PERIOD_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == '0);

endmodule

// File: rtl/dutsig_vector_seq.sv
// Sequencer feeding a bank of double-buffered DUT signal registers: LOADs each
// upstream vector, then TRANSFERs on a programmed period. Optional DUTSEQ_VEC_COUNT_EN adds vec_count.
module dutsig_vector_seq
  import dutsig_vector_seq_pkg::*;
#(
  parameter int NSIG     = 8,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic [NSIG-1:0]     vec_data,
  input  logic                vec_valid,
  output logic                vec_ready,
  output logic                load,
  output logic                transfer,
  output logic [NSIG-1:0]     d,
  output logic                busy,
  output logic                done,
  output logic                underrun,
`ifdef DUTSEQ_VEC_COUNT_EN
  output logic                cfg_err,
  output logic [CNT_W-1:0]    vec_count
`else
  output logic                cfg_err
`endif
);

  seq_state_e          state_r;
  logic                buf_full_r;
  logic [CNT_W-1:0]    loads_r;
  logic [CNT_W-1:0]    xfers_r;
  logic [PERIOD_W-1:0] period_r;
  logic [CNT_W-1:0]    num_vec_r;

  logic accept_s;
  logic timer_zero_s;
  logic cfg_legal_s;
  logic last_xfer_s;

  assign accept_s    = vec_valid && vec_ready;
  assign cfg_legal_s = (period >= PERIOD_W'(MIN_PERIOD)) && (num_vec != '0);
  assign last_xfer_s = (xfers_r == (num_vec_r - CNT_W'(1)));
  assign busy        = (state_r != ST_IDLE);

  dutsig_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state_r == ST_PRELOAD) && accept_s),
    .reload   (period_r - PERIOD_W'(1)),
    .enable   (state_r == ST_RUN),
    .terminal (timer_zero_s)
  );

  // Fetch is blocked on terminal cycles so a LOAD can never land on a TRANSFER.
  always_comb begin
    vec_ready = 1'b0;
    case (state_r)
      ST_PRELOAD: vec_ready = 1'b1;
      ST_RUN:     vec_ready = !buf_full_r && (loads_r < num_vec_r) && !timer_zero_s;
      default:    vec_ready = 1'b0;
    endcase
  end

  // Sequencer FSM, buffer tracking, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      buf_full_r <= 1'b0;
      loads_r    <= '0;
      xfers_r    <= '0;
      period_r   <= '0;
      num_vec_r  <= '0;
      load       <= 1'b0;
      transfer   <= 1'b0;
      d          <= '0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (abort) begin
      state_r    <= ST_IDLE;
      buf_full_r <= 1'b0;
      load       <= 1'b0;
      transfer   <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      load     <= 1'b0;
      transfer <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && cfg_legal_s) begin
            period_r   <= period;
            num_vec_r  <= num_vec;
            underrun   <= 1'b0;
            loads_r    <= '0;
            xfers_r    <= '0;
            buf_full_r <= 1'b0;
            state_r    <= ST_PRELOAD;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        ST_PRELOAD: begin
          if (accept_s) begin
            load       <= 1'b1;
            d          <= vec_data;
            buf_full_r <= 1'b1;
            loads_r    <= CNT_W'(1);
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (timer_zero_s) begin
            if (buf_full_r) begin
              transfer   <= 1'b1;
              buf_full_r <= 1'b0;
              xfers_r    <= xfers_r + CNT_W'(1);
              if (last_xfer_s) begin
                done    <= 1'b1;
                state_r <= ST_IDLE;
              end
            end else begin
              underrun <= 1'b1;
            end
          end else if (accept_s) begin
            load       <= 1'b1;
            d          <= vec_data;
            buf_full_r <= 1'b1;
            loads_r    <= loads_r + CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef DUTSEQ_VEC_COUNT_EN
  assign vec_count = xfers_r;
`else
`endif

endmodule

// File: tb/tb_dutsig_vector_seq.sv
// Directed self-checking bench for dutsig_vector_seq: normal runs, underrun,
// abort, configuration errors and asynchronous reset mid-run.
module tb_dutsig_vector_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] period = 16'd0;
  logic [15:0] num_vec = 16'd0;
  logic [7:0]  vec_data = 8'd0;
  logic        vec_valid = 1'b0;
  logic        vec_ready, load, transfer, busy, done, underrun, cfg_err;
  logic [7:0]  d;
`ifdef DUTSEQ_VEC_COUNT_EN
  logic [15:0] vec_count;
`endif

  dutsig_vector_seq #(.NSIG(8), .PERIOD_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .period(period), .num_vec(num_vec), .vec_data(vec_data), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .load(load), .transfer(transfer), .d(d),
    .busy(busy), .done(done), .underrun(underrun),
`ifdef DUTSEQ_VEC_COUNT_EN
    .cfg_err(cfg_err), .vec_count(vec_count)
`else
    .cfg_err(cfg_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] src_mem [4];
  int src_idx, src_cnt;
  logic src_on;
  int cyc, n_load, n_xfer, n_done, done_cyc, overlap, seq_err, since_load, t0;
  int xfer_cyc [8];
  logic [7:0] load_d [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic src_drive();
    vec_valid = src_on && (src_idx < src_cnt);
    vec_data  = (src_idx < 4) ? src_mem[src_idx] : 8'h00;
  endtask

  task automatic src_set(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int cnt);
    src_mem[0] = a; src_mem[1] = b; src_mem[2] = c; src_mem[3] = 8'h00;
    src_idx = 0; src_cnt = cnt; src_on = 1'b1;
    src_drive();
  endtask

  task automatic mon_clear();
    cyc = 0; n_load = 0; n_xfer = 0; n_done = 0; done_cyc = -1;
    overlap = 0; seq_err = 0; since_load = 0;
  endtask

  // One clock: inputs settle before the edge, outputs sampled on the falling edge.
  task automatic step();
    logic acc;
    acc = vec_valid && vec_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      src_idx++;
      src_drive();
    end
    @(negedge clk);
    cyc++;
    if (load && transfer) overlap++;
    if (load) begin
      if (n_load < 8) load_d[n_load] = d;
      n_load++;
      since_load++;
    end
    if (transfer) begin
      if (n_xfer < 8) xfer_cyc[n_xfer] = cyc;
      n_xfer++;
      if (since_load != 1) seq_err++;
      since_load = 0;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic kick(input logic [15:0] p, input logic [15:0] n);
    period = p; num_vec = n; start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 40 && n_done == 0; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    src_on = 1'b0; src_idx = 0; src_cnt = 0;
    mon_clear();
    repeat (2) @(negedge clk);
    check("rst_load", load, 0);
    check("rst_xfer", transfer, 0);
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ready", vec_ready, 0);
    rst_n = 1'b1;
    step();

    // Test 1: PERIOD=4, NUM_VEC=3, data always available; later PERIOD/NUM_VEC changes ignored.
    mon_clear();
    src_set(8'hA1, 8'hB2, 8'hC3, 3);
    kick(16'd4, 16'd3);
    period = 16'd9; num_vec = 16'd1;
    check("t1_busy", busy, 1);
    step();
    check("t1_load1", load, 1);
    check("t1_d1", d, 8'hA1);
    run_to_done();
    check("t1_ndone", n_done, 1);
    check("t1_nxfer", n_xfer, 3);
    check("t1_x0", xfer_cyc[0] - t0, 2);
    check("t1_x1", xfer_cyc[1] - t0, 6);
    check("t1_x2", xfer_cyc[2] - t0, 10);
    check("t1_done_cyc", done_cyc, xfer_cyc[2]);
    check("t1_d2", load_d[1], 8'hB2);
    check("t1_d3", load_d[2], 8'hC3);
    check("t1_underrun", underrun, 0);
    check("t1_busy_end", busy, 0);
    check("t1_overlap", overlap, 0);
    check("t1_seq", seq_err, 0);
`ifdef DUTSEQ_VEC_COUNT_EN
    check("t1_vec_count", vec_count, 3);
`endif
    step();

    // Test 2: PERIOD=3, NUM_VEC=2, second vector withheld for 8 cycles.
    mon_clear();
    src_set(8'h5A, 8'hA5, 8'h00, 1);
    kick(16'd3, 16'd2);
    step(); step();
    check("t2_first_xfer", transfer, 1);
    check("t2_underrun_early", underrun, 0);
    repeat (6) step();
    check("t2_underrun_set", underrun, 1);
    src_cnt = 2;
    src_drive();
    run_to_done();
    check("t2_ndone", n_done, 1);
    check("t2_nxfer", n_xfer, 2);
    check("t2_gap", xfer_cyc[1] - xfer_cyc[0], 9);
    check("t2_d2", load_d[1], 8'hA5);
    check("t2_underrun_sticky", underrun, 1);
    check("t2_overlap", overlap, 0);
    check("t2_seq", seq_err, 0);
    step();

    // START and ABORT together: ABORT wins, UNDERRUN not cleared.
    src_on = 1'b0; src_drive();
    period = 16'd4; num_vec = 16'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_underrun", underrun, 1);

    // Test 4: ABORT one cycle after the second LOAD, then a fresh run at PERIOD=2.
    mon_clear();
    src_set(8'h11, 8'h22, 8'h33, 3);
    kick(16'd4, 16'd3);
    for (int i = 0; i < 20 && n_load < 2; i++) step();
    check("t4_nload_pre", n_load, 2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy", busy, 0);
    repeat (12) step();
    check("t4_nload", n_load, 2);
    check("t4_nxfer", n_xfer, 1);
    check("t4_ndone", n_done, 0);
`ifdef DUTSEQ_VEC_COUNT_EN
    check("t4_vec_count", vec_count, 1);
`endif
    mon_clear();
    src_set(8'h44, 8'h55, 8'h00, 2);
    kick(16'd2, 16'd2);
    run_to_done();
    check("t4r_ndone", n_done, 1);
    check("t4r_nxfer", n_xfer, 2);
    check("t4r_gap", xfer_cyc[1] - xfer_cyc[0], 2);
    check("t4r_d2", load_d[1], 8'h55);
    check("t4r_overlap", overlap, 0);
    check("t4r_seq", seq_err, 0);
    step();

    // Test 5: illegal configurations.
    src_on = 1'b0; src_drive();
    kick(16'd1, 16'd3);
    check("t5a_cfg_err", cfg_err, 1);
    check("t5a_busy", busy, 0);
    step();
    check("t5a_cfg_err_pulse", cfg_err, 0);
    kick(16'd4, 16'd0);
    check("t5b_cfg_err", cfg_err, 1);
    check("t5b_busy", busy, 0);
    step();
    check("t5b_cfg_err_pulse", cfg_err, 0);

    // Test 6: asynchronous reset mid-run, then a normal run.
    mon_clear();
    src_set(8'h66, 8'h77, 8'h88, 3);
    kick(16'd4, 16'd3);
    for (int i = 0; i < 20 && n_xfer < 1; i++) step();
    check("t6_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_d", d, 0);
    check("t6_load", load, 0);
    check("t6_xfer", transfer, 0);
    check("t6_ready", vec_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_clear();
    src_set(8'h99, 8'hAA, 8'h00, 2);
    kick(16'd3, 16'd2);
    run_to_done();
    check("t6_ndone", n_done, 1);
    check("t6_nxfer", n_xfer, 2);
    check("t6_gap", xfer_cyc[1] - xfer_cyc[0], 3);
    check("t6_seq", seq_err, 0);
`ifdef DUTSEQ_VEC_COUNT_EN
    check("t6_vec_count", vec_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
